// File: rtl/hazard_ctrl_pkg.sv
// ============================================================================
// hazard_ctrl_pkg : shared encodings for the pipeline hazard controller
// Rev 1.0
// ============================================================================
`default_nettype none

package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } hz_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// ============================================================================
// hazard_fwd_unit : EX operand forwarding select for one source operand
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_fwd_unit
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rd_m,
  input  logic [REG_W-1:0] rd_w,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  output logic [1:0]       fwd_sel
);

  // MEM holds the younger result, so it is checked first
  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs_e)) begin
      fwd_sel = FWD_MEM;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs_e)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : stall/flush/forwarding control for the 5-stage RISC-V pipeline,
// with multi-cycle FP occupancy tracking. HAZARD_PERF_EN adds perf counters.
// Rev 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULTI_LAT = 4,
  parameter int REG_W     = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] Rs1E,
  input  logic [REG_W-1:0] Rs2E,
  input  logic [REG_W-1:0] RdE,
  input  logic [REG_W-1:0] RdM,
  input  logic [REG_W-1:0] RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic             MultiE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             Busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      PerfLwStall,
  output logic [31:0]      PerfFlush,
  output logic [31:0]      PerfMultiStall
`endif
);

  localparam int              CNT_W    = $clog2(MULTI_LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((MULTI_LAT > 1) ? (MULTI_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lw_stall;
  logic             multi_stall;

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_a (
    .rs_e(Rs1E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
    .fwd_sel(ForwardAE)
  );

  hazard_fwd_unit #(.REG_W(REG_W)) u_fwd_b (
    .rs_e(Rs2E), .rd_m(RdM), .rd_w(RdW),
    .reg_write_m(RegWriteM), .reg_write_w(RegWriteW),
    .fwd_sel(ForwardBE)
  );

  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // The trigger cycle itself stalls, so BUSY only covers the remaining MULTI_LAT-2
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    multi_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (MultiE && (MULTI_LAT > 1)) begin
          multi_stall = 1'b1;
          cnt_d       = CNT_LOAD;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          multi_stall = 1'b1;
          cnt_d       = cnt_q - CNT_ONE;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    if (multi_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushM = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      StallE = 1'b0;
      FlushD = PCSrcE;
      FlushE = lw_stall || PCSrcE;
      FlushM = 1'b0;
    end
  end

  assign Busy = multi_stall;

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_lw_q, perf_lw_d;
  logic [31:0] perf_fl_q, perf_fl_d;
  logic [31:0] perf_ms_q, perf_ms_d;

  always_comb begin
    perf_lw_d = (perf_lw_q == 32'hFFFF_FFFF) ? perf_lw_q : perf_lw_q + 32'(lw_stall);
    perf_fl_d = (perf_fl_q == 32'hFFFF_FFFF) ? perf_fl_q : perf_fl_q + 32'(PCSrcE);
    perf_ms_d = (perf_ms_q == 32'hFFFF_FFFF) ? perf_ms_q : perf_ms_q + 32'(multi_stall);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lw_q <= '0;
      perf_fl_q <= '0;
      perf_ms_q <= '0;
    end else begin
      perf_lw_q <= perf_lw_d;
      perf_fl_q <= perf_fl_d;
      perf_ms_q <= perf_ms_d;
    end
  end

  assign PerfLwStall    = perf_lw_q;
  assign PerfFlush      = perf_fl_q;
  assign PerfMultiStall = perf_ms_q;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage RISC-V integer pipeline.
- Drives stall, flush and forwarding selects for the IF/ID, ID/EX and EX/MEM registers.
- Freezes the front of the pipeline while a multi-cycle floating-point op occupies EX. This uses an internal occupancy FSM and counter.
- Resolves load-use stalls and taken-branch flushes.

Parameters:
- MULTI_LAT, 4: total EX occupancy in cycles of a multi-cycle op. Legal range 1..16; 1 means no stall.
- REG_W, 5: register index width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- Rs1D, Rs2D  in  REG_W  source registers in ID
- Rs1E, Rs2E, RdE  in  REG_W  source and destination registers in EX
- RdM, RdW  in  REG_W  destination registers in MEM and WB
- RegWriteM, RegWriteW  in  1  write enables in MEM and WB
- ResultSrcE  in  2  result select in EX; 2'b01 = load
- PCSrcE  in  1  taken branch or jump in EX
- MultiE  in  1  instruction in EX is a multi-cycle FP op
- StallF, StallD, StallE  out  1  hold PC, IF/ID and ID/EX
- FlushD, FlushE, FlushM  out  1  bubble into IF/ID, ID/EX and EX/MEM
- ForwardAE, ForwardBE  out  2  operand select: 00 register file, 01 WB result, 10 MEM ALU result
- Busy  out  1  multi-cycle op is in progress

Behaviour:
- Clocking and reset: one clock, clk. reset is asynchronous and active-high. On reset: state=IDLE, cnt=0.
- Outputs are combinational from state and inputs. With reset asserted and all inputs 0, every output is 0.
- Forwarding (always active, independent of stalls):
  - ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Else ForwardAE=01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Else 00. MEM has priority over WB.
  - ForwardBE is identical, using Rs2E.
- Load-use: lwStall = (ResultSrcE==01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- FSM states: IDLE, BUSY. cnt has width $clog2(MULTI_LAT)+1.
- IDLE with MultiE=1 and MULTI_LAT>1:
  - multiStall=1 this cycle.
  - cnt <= MULTI_LAT-2.
  - next state BUSY.
- BUSY:
  - cnt!=0: multiStall=1, cnt decrements.
  - cnt==0: multiStall=0, next state IDLE. The op leaves EX at this edge.
  - MultiE is not sampled in BUSY, so the same op cannot retrigger.
- Stall cycles per multi-cycle op = MULTI_LAT-1. EX occupancy = MULTI_LAT.
- Busy=1 whenever multiStall=1.
- Output equations:
  - While multiStall=1: StallF=StallD=StallE=1 and FlushM=1. FlushD=FlushE=0. lwStall is masked because the pipeline is frozen.
  - Otherwise: StallF=StallD=lwStall, StallE=0, FlushD=PCSrcE, FlushE=lwStall||PCSrcE, FlushM=0.
- Simultaneous lwStall and PCSrcE: the flush wins for D. Both FlushE and the stalls assert; the stalled fetch is discarded by the redirect.
- MultiE and PCSrcE in the same cycle is illegal; the bench asserts it never occurs. If it does, the multi-stall path takes precedence.
- Reset mid-BUSY: immediate return to IDLE, all stalls drop asynchronously.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds outputs PerfLwStall, PerfFlush and PerfMultiStall, 32 bits each.
  - They count cycles with lwStall (unmasked), PCSrcE, and multiStall respectively.
  - They saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and counters do not exist; control behaviour is identical.

Decomposition:
- Shared package holds:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RES_LOAD=2'b01.
  - The state enum {IDLE, BUSY}.
- One sub-module, hazard_fwd_unit: pure combinational forwarding muxes, instantiated once per operand.
- FSM and stall/flush logic stay in the top module.

Test Plan:
- Forwarding: RdM=5, RegWriteM=1, Rs1E=5, and RdW=5, RegWriteW=1 -> ForwardAE=10. With RdM=0 instead -> ForwardAE=01. With Rs2E=0 and RdW=0 -> ForwardBE=00.
- Load-use: ResultSrcE=01, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. With RdE=0 -> no stall.
- Branch: PCSrcE=1 for one cycle -> FlushD=FlushE=1, StallF=0.
- Multi-cycle (MULTI_LAT=4): MultiE=1 in IDLE -> StallF/D/E and FlushM high for exactly 3 cycles, Busy for 3 cycles, then state IDLE.
- Multi-cycle with MULTI_LAT=1: MultiE=1 -> no stall, state stays IDLE.
- Reset during the 2nd BUSY cycle: all stalls drop before the next edge; a following MultiE=1 restarts the full 3-cycle stall.
- With HAZARD_PERF_EN: 2 load-use stalls + 1 multi-cycle op (MULTI_LAT=4) -> PerfLwStall=2, PerfMultiStall=3.
